// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: stage register fields in,
// pipeline-register enables / bubble controls / forwarding selects out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic [4:0]       wb_rd;
    logic             wb_regwrite;
    logic             mem_req;
    logic             dmem_ack;
    logic             br_taken;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic             halted;
    logic [1:0]       state;

    // pipeline datapath side
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output mem_req, dmem_ack, br_taken,
        input  pc_en, ifid_en, idex_en, exmem_en,
        input  ifid_flush, idex_flush, memwb_flush,
        input  fwd_a, fwd_b, stall_cnt, halted, state
    );

    // hazard controller side
    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  mem_req, dmem_ack, br_taken,
        output pc_en, ifid_en, idex_en, exmem_en,
        output ifid_flush, idex_flush, memwb_flush,
        output fwd_a, fwd_b, stall_cnt, halted, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: memory freeze/timeout FSM, branch flush,
// data stalls and stall-cycle counter. Define FORWARD_EN to enable ALU forwarding.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic       ex_hit_c, data_stall_c, freeze_c;
    logic       pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
    logic       ifid_flush_c, idex_flush_c, memwb_flush_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    // R0 is hardwired, so a write to it never creates a dependency
    function automatic logic reg_match(input logic wr, input logic [4:0] rd,
                                       input logic [4:0] src);
        return wr && (rd != 5'd0) && (rd == src);
    endfunction

`ifdef FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (reg_match(bus.mem_regwrite, bus.mem_rd, src)) return 2'b10;
        if (reg_match(bus.wb_regwrite, bus.wb_rd, src))   return 2'b01;
        return 2'b00;
    endfunction
`endif

    // data dependency detection; WB producers are covered by write-before-read
    always_comb begin
        ex_hit_c = (bus.id_use_rs && reg_match(bus.ex_regwrite, bus.ex_rd, bus.id_rs)) ||
                   (bus.id_use_rt && reg_match(bus.ex_regwrite, bus.ex_rd, bus.id_rt));
`ifdef FORWARD_EN
        data_stall_c = bus.ex_memread && ex_hit_c;
        fwd_a_c      = fwd_sel(bus.ex_rs);
        fwd_b_c      = fwd_sel(bus.ex_rt);
`else
        data_stall_c = ex_hit_c ||
            (bus.id_use_rs && reg_match(bus.mem_regwrite, bus.mem_rd, bus.id_rs)) ||
            (bus.id_use_rt && reg_match(bus.mem_regwrite, bus.mem_rd, bus.id_rt));
        fwd_a_c      = 2'b00;
        fwd_b_c      = 2'b00;
`endif
        if (!rst) begin
            fwd_a_c = 2'b00;
            fwd_b_c = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    // next state and pipeline controls: HALT > freeze > branch > data stall
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        stall_d       = stall_q;
        freeze_c      = 1'b0;
        pc_en_c       = 1'b0;
        ifid_en_c     = 1'b0;
        idex_en_c     = 1'b0;
        exmem_en_c    = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        memwb_flush_c = 1'b0;

        unique case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                freeze_c = (state_q == ST_RUN) ? (bus.mem_req && !bus.dmem_ack)
                                               : !bus.dmem_ack;
                if (freeze_c) begin
                    memwb_flush_c = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d = ST_MEM_WAIT;
                        wait_d  = '0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = ST_HALT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    state_d    = ST_RUN;
                    pc_en_c    = 1'b1;
                    ifid_en_c  = 1'b1;
                    idex_en_c  = 1'b1;
                    exmem_en_c = 1'b1;
                    if (bus.br_taken) begin
                        ifid_flush_c = 1'b1;
                        idex_flush_c = 1'b1;
                    end else if (data_stall_c) begin
                        pc_en_c      = 1'b0;
                        ifid_en_c    = 1'b0;
                        idex_flush_c = 1'b1;
                    end
                end
                if (!pc_en_c && (stall_q != '1)) begin
                    stall_d = stall_q + CNT_W'(1);
                end
            end
            ST_HALT: ;
            default: state_d = ST_RUN;
        endcase

        if (!rst) begin
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_en_c     = 1'b0;
            exmem_en_c    = 1'b0;
            ifid_flush_c  = 1'b0;
            idex_flush_c  = 1'b0;
            memwb_flush_c = 1'b0;
        end
    end

    assign bus.pc_en       = pc_en_c;
    assign bus.ifid_en     = ifid_en_c;
    assign bus.idex_en     = idex_en_c;
    assign bus.exmem_en    = exmem_en_c;
    assign bus.ifid_flush  = ifid_flush_c;
    assign bus.idex_flush  = idex_flush_c;
    assign bus.memwb_flush = memwb_flush_c;
    assign bus.fwd_a       = fwd_a_c;
    assign bus.fwd_b       = fwd_b_c;
    assign bus.stall_cnt   = stall_q;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.state       = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios plus random
// stimulus, checked against a rule-level model of the controller.
module tb_pipe_hazard_ctrl;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned TMO   = 15;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
    typedef struct packed {
        logic [6:0]       ctl;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] sc;
        logic             halted;
        logic [1:0]       st;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // model: mode 0 running, 1 waiting on memory, 2 halted
    int m_mode  = 0;
    int m_waits = 0;
    int m_stall = 0;

    function automatic bit writes(logic wr, logic [4:0] rd, logic [4:0] src);
        return wr && rd != 0 && rd == src;
    endfunction

    function automatic bit blocked(logic used, logic [4:0] src);
        if (!used) return 0;
`ifdef FORWARD_EN
        return bus.ex_memread && writes(bus.ex_regwrite, bus.ex_rd, src);
`else
        return writes(bus.ex_regwrite, bus.ex_rd, src) || writes(bus.mem_regwrite, bus.mem_rd, src);
`endif
    endfunction

    function automatic logic [1:0] fwd_model(logic [4:0] src);
`ifdef FORWARD_EN
        if (writes(bus.mem_regwrite, bus.mem_rd, src)) return 2'b10;
        if (writes(bus.wb_regwrite, bus.wb_rd, src))   return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic bit model_freeze();
        if (m_mode == 0) return bus.mem_req && !bus.dmem_ack;
        if (m_mode == 1) return !bus.dmem_ack;
        return 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        if (!rst) return e;
        e.fa     = fwd_model(bus.ex_rs);
        e.fb     = fwd_model(bus.ex_rt);
        e.st     = 2'(m_mode);
        e.sc     = CNT_W'(m_stall);
        e.halted = (m_mode == 2);
        if (m_mode == 2)                e.ctl = 7'b0000000;
        else if (model_freeze())        e.ctl = 7'b0000001;
        else if (bus.br_taken)          e.ctl = 7'b1111110;
        else if (blocked(bus.id_use_rs, bus.id_rs) || blocked(bus.id_use_rt, bus.id_rt))
                                        e.ctl = 7'b0011010;
        else                            e.ctl = 7'b1111000;
        return e;
    endfunction

    task automatic model_update(input exp_t e);
        bit fz;
        if (!rst) begin
            m_mode = 0; m_waits = 0; m_stall = 0;
            return;
        end
        fz = model_freeze();
        if (m_mode != 2 && !e.ctl[6] && m_stall < SAT) m_stall++;
        if (m_mode == 0 && fz) begin
            m_mode = 1; m_waits = 0;
        end else if (m_mode == 1) begin
            if (bus.dmem_ack) m_mode = 0;
            else begin
                m_waits++;
                if (m_waits == TMO) m_mode = 2;
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        e = model_out();
        q.push_back(e);
        model_update(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_idle();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_rd = 0;
        bus.ex_regwrite = 0; bus.ex_memread = 0;
        bus.mem_rd = 0; bus.mem_regwrite = 0; bus.wb_rd = 0; bus.wb_regwrite = 0;
        bus.mem_req = 0; bus.dmem_ack = 0; bus.br_taken = 0;
    endtask

    task automatic set_random();
        bus.id_rs        = 5'($urandom_range(0, 3));
        bus.id_rt        = 5'($urandom_range(0, 3));
        bus.id_use_rs    = 1'($urandom_range(0, 1));
        bus.id_use_rt    = 1'($urandom_range(0, 1));
        bus.ex_rs        = 5'($urandom_range(0, 3));
        bus.ex_rt        = 5'($urandom_range(0, 3));
        bus.ex_rd        = 5'($urandom_range(0, 3));
        bus.ex_regwrite  = 1'($urandom_range(0, 1));
        bus.ex_memread   = ($urandom_range(0, 9) < 3);
        bus.mem_rd       = 5'($urandom_range(0, 3));
        bus.mem_regwrite = 1'($urandom_range(0, 1));
        bus.wb_rd        = 5'($urandom_range(0, 3));
        bus.wb_regwrite  = 1'($urandom_range(0, 1));
        bus.mem_req      = ($urandom_range(0, 4) == 0);
        bus.dmem_ack     = ($urandom_range(0, 9) < 6);
        bus.br_taken     = ($urandom_range(0, 7) == 0);
        rst = (m_mode == 2) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 99) != 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // monitor: every cycle the DUT presents a control word; compare mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ctl", 32'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                            bus.ifid_flush, bus.idex_flush, bus.memwb_flush}), 32'(e.ctl));
            chk("fwd_a", 32'(bus.fwd_a), 32'(e.fa));
            chk("fwd_b", 32'(bus.fwd_b), 32'(e.fb));
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(e.sc));
            chk("halted", 32'(bus.halted), 32'(e.halted));
            chk("state", 32'(bus.state), 32'(e.st));
        end
    end

    initial begin
        set_idle();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        run(2);
        rst = 1'b1;
        run(2);

        // load-use: lw R22 in EX, add R23,R21,R22 in ID
        bus.ex_rd = 22; bus.ex_regwrite = 1; bus.ex_memread = 1;
        bus.id_rs = 21; bus.id_rt = 22; bus.id_use_rs = 1; bus.id_use_rt = 1;
        cycle();
        bus.ex_rd = 0; bus.ex_regwrite = 0; bus.ex_memread = 0;
        bus.mem_rd = 22; bus.mem_regwrite = 1;
        cycle();
        bus.mem_rd = 0; bus.mem_regwrite = 0; bus.wb_rd = 22; bus.wb_regwrite = 1;
        bus.ex_rs = 21; bus.ex_rt = 22;
        bus.id_use_rs = 0; bus.id_use_rt = 0;
        cycle();
        set_idle();
        run(1);

        // memory freeze: three cycles without ack then ack
        bus.mem_req = 1; bus.dmem_ack = 0;
        run(3);
        bus.dmem_ack = 1;
        cycle();
        set_idle();
        run(1);

        // branch coincident with load-use
        bus.ex_rd = 7; bus.ex_regwrite = 1; bus.ex_memread = 1;
        bus.id_rs = 7; bus.id_use_rs = 1; bus.br_taken = 1;
        cycle();
        set_idle();

        // R0 never matches; MEM beats WB on forwarding
        bus.ex_rd = 0; bus.ex_regwrite = 1; bus.ex_memread = 1;
        bus.id_rs = 0; bus.id_use_rs = 1;
        bus.mem_rd = 5; bus.mem_regwrite = 1; bus.wb_rd = 5; bus.wb_regwrite = 1;
        bus.ex_rs = 5;
        cycle();
        set_idle();
        run(1);

        // memory timeout into HALT, then reset out of it
        bus.mem_req = 1; bus.dmem_ack = 0;
        run(TMO + 4);
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        set_idle();
        run(1);

        // stall counter saturation under a held load-use
        bus.ex_rd = 3; bus.ex_regwrite = 1; bus.ex_memread = 1;
        bus.id_rt = 3; bus.id_use_rt = 1;
        run(SAT + 6);
        rst = 1'b0;
        set_idle();
        cycle();
        rst = 1'b1;

        for (int i = 0; i < 800; i++) begin
            set_random();
            cycle();
        end

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for dmem_ack before halting.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports id_rs, id_rt  in  5 each  ID-stage source registers.
REQ-006 SHALL have ports id_use_rs, id_use_rt  in  1 each  ID instruction reads that source.
REQ-007 SHALL have ports ex_rs, ex_rt, ex_rd  in  5 each  EX-stage register fields; ex_rd is the resolved destination.
REQ-008 SHALL have ports ex_regwrite, ex_memread  in  1 each  EX-stage control bits.
REQ-009 SHALL have ports mem_rd  in  5 and mem_regwrite  in  1  MEM-stage destination.
REQ-010 SHALL have ports wb_rd  in  5 and wb_regwrite  in  1  WB-stage destination.
REQ-011 SHALL have ports mem_req  in  1 (MEM stage holds lw/sw) and dmem_ack  in  1 (data memory completed access).
REQ-012 SHALL have port br_taken  in  1  branch/jump resolved taken in EX.
REQ-013 SHALL have ports pc_en, ifid_en, idex_en, exmem_en  out  1 each  pipeline-register load enables.
REQ-014 SHALL have ports ifid_flush, idex_flush, memwb_flush  out  1 each  insert-bubble controls.
REQ-015 SHALL have ports fwd_a, fwd_b  out  2 each  ALU operand select: 00 regfile, 01 WB, 10 MEM.
REQ-016 SHALL have ports stall_cnt  out  CNT_W, halted  out  1, and state  out  2.

Function
REQ-017 SHALL implement FSM states RUN=00, MEM_WAIT=01, HALT=10; all outputs derive combinationally from state, inputs and registers.
REQ-018 A register match SHALL require producer regwrite=1, producer rd != 0, and equality with the consumer source; R0 never matches.
REQ-019 In RUN with mem_req=1 and dmem_ack=0, the FSM SHALL move to MEM_WAIT; in that same cycle, and every MEM_WAIT cycle without ack, pc_en=ifid_en=idex_en=exmem_en=0 and memwb_flush=1.
REQ-020 In MEM_WAIT, dmem_ack=1 SHALL release the freeze in that cycle (normal RUN outputs) and return to RUN next edge.
REQ-021 A wait counter SHALL reset on MEM_WAIT entry; when MEM_TIMEOUT cycles elapse without ack, the FSM SHALL enter HALT.
REQ-022 HALT SHALL drive all enables 0, flushes 0 and halted=1 until reset.
REQ-023 Load-use (RUN, no memory freeze, ex_memread=1, ex_rd matches a used ID source) SHALL hold for exactly one cycle: pc_en=0, ifid_en=0, idex_flush=1.
REQ-024 br_taken=1 in RUN without memory freeze SHALL assert ifid_flush=1 and idex_flush=1 with all enables 1 for one cycle.
REQ-025 Priority SHALL be HALT > memory freeze > branch flush > data stall; a simultaneous branch and load-use SHALL produce only the branch flush.
REQ-026 Register file is write-before-read; WB-stage matches SHALL never cause an ID stall.
REQ-027 stall_cnt SHALL increment on every cycle with pc_en=0 outside HALT, saturating at all-ones.
REQ-028 With no hazard, all enables SHALL be 1 and all flushes 0.

Reset
REQ-029 rst=0 SHALL asynchronously force state=RUN, stall_cnt=0, wait counter=0, halted=0.
REQ-030 While rst=0, all enables and flushes SHALL be 0 and fwd_a=fwd_b=00; reset mid-MEM_WAIT or HALT SHALL abandon the access.

Configuration
REQ-031 Macro FORWARD_EN defined SHALL enable forwarding: fwd_a/fwd_b = 10 on MEM match with ex_rs/ex_rt, else 01 on WB match, else 00 (MEM wins).
REQ-032 With FORWARD_EN defined, the only data stall SHALL be load-use per REQ-023.
REQ-033 Without FORWARD_EN, fwd_a=fwd_b=00 constantly, and any used ID source matching ex_rd or mem_rd SHALL stall per REQ-023 each cycle until no match remains.

Verification
REQ-034 lw R22,2000(R0) in EX; add R23,R21,R22 in ID -> one cycle pc_en=0, idex_flush=1; next cycle fwd_b=01 (FORWARD_EN).
REQ-035 Same sequence without FORWARD_EN -> two consecutive stall cycles; stall_cnt goes 0->2; fwd_b stays 00.
REQ-036 mem_req=1, dmem_ack low 3 cycles then high -> 3 freeze cycles with memwb_flush=1, then RUN; stall_cnt=3.
REQ-037 mem_req=1, dmem_ack never asserted, MEM_TIMEOUT=15 -> HALT after 15 cycles, halted=1, enables 0; rst low clears to RUN.
REQ-038 br_taken=1 coincident with load-use -> ifid_flush=idex_flush=1, pc_en=1, stall_cnt unchanged.
REQ-039 ex_rd=0, ex_memread=1, id_rs=0 used -> no stall; mem_rd=wb_rd=5 both writing, ex_rs=5 -> fwd_a=10.
